// File: rtl/func_stream_sched_pkg.sv
// Shared types and default widths for the stream run controller.
package func_stream_sched_pkg;

  localparam int unsigned DEFAULT_COUNT_WIDTH  = 32;
  localparam int unsigned DEFAULT_NUM_CHANNELS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/func_stream_sched_if.sv
// Handshake bundle between input channels, kernel pipeline and output sink.
// master: the run controller; slave: the surrounding stream/kernel fabric.
interface func_stream_sched_if
  import func_stream_sched_pkg::*;
#(
  parameter int unsigned C_NUM_CHANNELS = DEFAULT_NUM_CHANNELS
);

  logic [C_NUM_CHANNELS-1:0] s_tvalid;
  logic [C_NUM_CHANNELS-1:0] s_tready;
  logic                      k_ivalid;
  logic                      k_iready;
  logic                      k_ovalid;
  logic                      k_oready;
  logic                      m_tvalid;
  logic                      m_tready;

  modport master (
    input  s_tvalid, k_iready, k_ovalid, m_tready,
    output s_tready, k_ivalid, k_oready, m_tvalid
  );

  modport slave (
    output s_tvalid, k_iready, k_ovalid, m_tready,
    input  s_tready, k_ivalid, k_oready, m_tvalid
  );

endinterface

// File: rtl/func_beat_counter.sv
// Beat counter with synchronous clear, enable increment and limit compare.
module func_beat_counter
  import func_stream_sched_pkg::*;
#(
  parameter int unsigned C_COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     i_clr,
  input  logic                     i_inc,
  input  logic [C_COUNT_WIDTH-1:0] i_limit,
  output logic [C_COUNT_WIDTH-1:0] o_cnt,
  output logic                     o_open_c,
  output logic                     o_last_c
);

  localparam int unsigned W_EXT = C_COUNT_WIDTH + 1;

  logic [C_COUNT_WIDTH-1:0] r_cnt;
  logic [W_EXT-1:0]         w_cnt_plus1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + C_COUNT_WIDTH'(1);
    end
  end

  // Extended compare so a limit of all-ones never aliases on overflow.
  assign w_cnt_plus1 = W_EXT'(r_cnt) + W_EXT'(1);
  assign o_open_c    = (r_cnt < i_limit);
  assign o_last_c    = (w_cnt_plus1 == W_EXT'(i_limit));
  assign o_cnt       = r_cnt;

endmodule

// File: rtl/func_stream_sched.sv
// Run controller gating the input join and output handshake for LEN beats.
// Optional FUNC_STREAM_SCHED_PERF_EN adds run_cycles / stall_cycles counters.
module func_stream_sched
  import func_stream_sched_pkg::*;
#(
  parameter int unsigned C_NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
  parameter int unsigned C_COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic [C_COUNT_WIDTH-1:0] len,
  output logic                     busy,
  output logic                     done,
  func_stream_sched_if.master      strm,
  output logic [C_COUNT_WIDTH-1:0] in_cnt,
  output logic [C_COUNT_WIDTH-1:0] out_cnt
`ifdef FUNC_STREAM_SCHED_PERF_EN
  ,
  output logic [C_COUNT_WIDTH-1:0] run_cycles,
  output logic [C_COUNT_WIDTH-1:0] stall_cycles
`endif
);

  sched_state_t             r_state;
  logic [C_COUNT_WIDTH-1:0] r_len_q;
  logic                     r_busy;
  logic                     r_done;

  logic w_start_acc;
  logic w_all_valid;
  logic w_in_open;
  logic w_out_open;
  logic w_in_fire;
  logic w_out_fire;
  logic w_in_cnt_open;
  logic w_in_last;
  logic w_out_cnt_open;
  logic w_out_last;
  logic w_out_complete;

  assign w_start_acc = (r_state == IDLE) & start;

  // Input join: every channel must be valid before the kernel sees a beat.
  assign w_all_valid   = &strm.s_tvalid;
  assign w_in_open     = (r_state == RUN) & w_in_cnt_open;
  assign strm.k_ivalid = w_in_open & w_all_valid;
  assign strm.s_tready = {C_NUM_CHANNELS{w_in_open & strm.k_iready & w_all_valid}};
  assign w_in_fire     = strm.k_ivalid & strm.k_iready;

  assign w_out_open    = ((r_state == RUN) | (r_state == DRAIN)) & w_out_cnt_open;
  assign strm.m_tvalid = w_out_open & strm.k_ovalid;
  assign strm.k_oready = w_out_open & strm.m_tready;
  assign w_out_fire    = strm.m_tvalid & strm.m_tready;

  // Output side already finished, or finishing on this very cycle.
  assign w_out_complete = (w_out_fire & w_out_last) | ~w_out_cnt_open;

  func_beat_counter #(.C_COUNT_WIDTH(C_COUNT_WIDTH)) u_in_counter (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_clr    (w_start_acc),
    .i_inc    (w_in_fire),
    .i_limit  (r_len_q),
    .o_cnt    (in_cnt),
    .o_open_c (w_in_cnt_open),
    .o_last_c (w_in_last)
  );

  func_beat_counter #(.C_COUNT_WIDTH(C_COUNT_WIDTH)) u_out_counter (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_clr    (w_start_acc),
    .i_inc    (w_out_fire),
    .i_limit  (r_len_q),
    .o_cnt    (out_cnt),
    .o_open_c (w_out_cnt_open),
    .o_last_c (w_out_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_len_q <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len_q <= len;
            if (len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_in_fire && w_in_last) begin
            if (w_out_complete) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_out_fire && w_out_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

`ifdef FUNC_STREAM_SCHED_PERF_EN
  logic [C_COUNT_WIDTH-1:0] r_run_cycles;
  logic [C_COUNT_WIDTH-1:0] r_stall_cycles;
  logic                     w_stall;

  assign w_stall = (strm.k_ivalid & ~strm.k_iready) | (strm.m_tvalid & ~strm.m_tready);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_run_cycles   <= '0;
      r_stall_cycles <= '0;
    end else if (w_start_acc) begin
      r_run_cycles   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_busy) begin
        r_run_cycles <= r_run_cycles + C_COUNT_WIDTH'(1);
      end
      if (w_stall) begin
        r_stall_cycles <= r_stall_cycles + C_COUNT_WIDTH'(1);
      end
    end
  end

  assign run_cycles   = r_run_cycles;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_func_stream_sched.sv
// Directed bench for func_stream_sched with a 2-stage kernel delay model.
module tb_func_stream_sched;
  import func_stream_sched_pkg::*;

  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 32;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b1;
  logic          start   = 1'b0;
  logic [CW-1:0] len     = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
`ifdef FUNC_STREAM_SCHED_PERF_EN
  logic [CW-1:0] run_cycles;
  logic [CW-1:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  func_stream_sched_if #(.C_NUM_CHANNELS(NCH)) strm ();

  func_stream_sched #(.C_NUM_CHANNELS(NCH), .C_COUNT_WIDTH(CW)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .strm         (strm),
    .in_cnt       (in_cnt),
    .out_cnt      (out_cnt)
`ifdef FUNC_STREAM_SCHED_PERF_EN
    ,
    .run_cycles   (run_cycles),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 aclk = ~aclk;

  // Kernel model: accepted beats appear at the output two cycles later.
  logic kd1, kd2;
  int   kavail;
  logic kov_force = 1'b0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      kd1    <= 1'b0;
      kd2    <= 1'b0;
      kavail <= 0;
    end else begin
      kd1    <= strm.k_ivalid & strm.k_iready;
      kd2    <= kd1;
      kavail <= kavail + int'(kd2) - int'(strm.m_tvalid & strm.m_tready);
    end
  end

  assign strm.k_ovalid = kov_force | (kavail > 0);

  int out_fires = 0;
  int done_seen = 0;
  bit both_high = 1'b0;

  always @(posedge aclk) begin
    if (strm.m_tvalid && strm.m_tready) out_fires <= out_fires + 1;
    if (done) done_seen <= done_seen + 1;
  end

  always @(negedge aclk) begin
    if (busy && done) both_high <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_o;
    int base_d;
    bit bad;

    strm.s_tvalid = '0;
    strm.k_iready = 1'b0;
    strm.m_tready = 1'b0;

    // Reset values
    #2 aresetn = 1'b0;
    #1;
    check("rst_busy",    64'(busy),          64'd0);
    check("rst_done",    64'(done),          64'd0);
    check("rst_in_cnt",  64'(in_cnt),        64'd0);
    check("rst_out_cnt", 64'(out_cnt),       64'd0);
    check("rst_s_tready",64'(strm.s_tready), 64'd0);
    check("rst_k_ivalid",64'(strm.k_ivalid), 64'd0);
    tick();
    tick();
    aresetn = 1'b1;
    tick();

    // Test 1: len=4, everything ready
    strm.s_tvalid = 2'b11;
    strm.k_iready = 1'b1;
    strm.m_tready = 1'b1;
    len    = 32'd4;
    start  = 1'b1;
    base_o = out_fires;
    base_d = done_seen;
    tick();
    start = 1'b0;
    check("t1_busy_run",  64'(busy),   64'd1);
    check("t1_in_cnt0",   64'(in_cnt), 64'd0);
    repeat (4) tick();
    check("t1_in_cnt4",   64'(in_cnt), 64'd4);
    check("t1_busy_mid",  64'(busy),   64'd1);
    wait_done("t1_done");
    check("t1_busy_at_done", 64'(busy),    64'd0);
    check("t1_out_cnt",      64'(out_cnt), 64'd4);
    tick();
    check("t1_done_pulse",   64'(done),               64'd0);
    check("t1_out_fires",    64'(out_fires - base_o), 64'd4);
    check("t1_done_count",   64'(done_seen - base_d), 64'd1);

    // Test 2: len=0 goes straight to DONE
    len   = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_done",     64'(done),          64'd1);
    check("t2_busy",     64'(busy),          64'd0);
    check("t2_s_tready", 64'(strm.s_tready), 64'd0);
    tick();
    check("t2_done_off", 64'(done), 64'd0);
    check("t2_idle",     64'(busy), 64'd0);

    // Test 3: partial valid blocks the join
    len           = 32'd2;
    strm.s_tvalid = 2'b01;
    start         = 1'b1;
    tick();
    start = 1'b0;
    bad   = 1'b0;
    repeat (5) begin
      if (strm.s_tready != 2'b00 || strm.k_ivalid || in_cnt != 0) bad = 1'b1;
      tick();
    end
    check("t3_partial_gate", 64'(bad), 64'd0);
    strm.s_tvalid = 2'b11;
    #1;
    check("t3_both_ready", 64'(strm.s_tready), 64'd3);
    tick();
    check("t3_in_cnt1", 64'(in_cnt), 64'd1);
    wait_done("t3_done");
    check("t3_out_cnt", 64'(out_cnt), 64'd2);
    tick();

    // Test 4: sink stalled for 10 cycles, then a forced extra kernel valid
    strm.m_tready = 1'b0;
    len           = 32'd3;
    start         = 1'b1;
    tick();
    start = 1'b0;
    bad   = 1'b0;
    repeat (10) begin
      if (strm.k_oready || out_cnt != 0) bad = 1'b1;
      tick();
    end
    check("t4_stall_frozen", 64'(bad),    64'd0);
    check("t4_in_cnt3",      64'(in_cnt), 64'd3);
    check("t4_drain_busy",   64'(busy),   64'd1);
    base_o        = out_fires;
    strm.m_tready = 1'b1;
    kov_force     = 1'b1;
    wait_done("t4_done");
    check("t4_out_cnt3",     64'(out_cnt),       64'd3);
    check("t4_no_m_tvalid",  64'(strm.m_tvalid), 64'd0);
    tick();
    check("t4_out_fires",    64'(out_fires - base_o), 64'd3);
    check("t4_no_k_oready",  64'(strm.k_oready),      64'd0);
    kov_force = 1'b0;

    // Test 5: async reset mid-run, then a short run
    len   = 32'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t5_in_cnt2", 64'(in_cnt), 64'd2);
    aresetn = 1'b0;
    #1;
    check("t5_rst_busy",     64'(busy),          64'd0);
    check("t5_rst_in_cnt",   64'(in_cnt),        64'd0);
    check("t5_rst_s_tready", 64'(strm.s_tready), 64'd0);
    check("t5_rst_k_ivalid", 64'(strm.k_ivalid), 64'd0);
    check("t5_rst_m_tvalid", 64'(strm.m_tvalid), 64'd0);
    tick();
    aresetn = 1'b1;
    tick();
    check("t5_idle_busy", 64'(busy), 64'd0);
    len   = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5_done");
    check("t5_out_cnt1", 64'(out_cnt), 64'd1);
    tick();

    // Test 6: start held across DONE
    len   = 32'd1;
    start = 1'b1;
    tick();
    check("t6_busy", 64'(busy), 64'd1);
    wait_done("t6_done");
    check("t6_in_cnt_final", 64'(in_cnt), 64'd1);
    tick();
    check("t6_idle_busy",    64'(busy),   64'd0);
    check("t6_idle_hold",    64'(in_cnt), 64'd1);
    tick();
    check("t6_rerun_busy",   64'(busy),    64'd1);
    check("t6_rerun_in_clr", 64'(in_cnt),  64'd0);
    check("t6_rerun_out_clr",64'(out_cnt), 64'd0);
    start = 1'b0;
    wait_done("t6_done2");
    tick();

    check("busy_done_exclusive", 64'(both_high), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/func_stream_sched.md
Name: func_stream_sched

Overview:
- Run controller that sits between the AXI-stream input/output channels and the generated kernel pipeline top.
- Accepts a run command carrying an element count, and gates the all-channel input join and the output handshake so that exactly LEN words enter and exactly LEN words leave.
- Reports busy/done to the host-side control logic.
- Handles handshakes only; data buses bypass this block.

Parameters:
- C_NUM_CHANNELS, 2, number of input stream channels joined into one kernel handshake.
- C_COUNT_WIDTH, 32, width of the length and element counters.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- len  in  C_COUNT_WIDTH  element count for the run; latched when start is accepted.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on run completion.
- s_tvalid  in  C_NUM_CHANNELS  per-channel input valid.
- s_tready  out  C_NUM_CHANNELS  per-channel input ready.
- k_ivalid  out  1  joined valid to the kernel.
- k_iready  in  1  kernel back-pressure.
- k_ovalid  in  1  kernel output valid.
- k_oready  out  1  ready to the kernel output.
- m_tvalid  out  1  output stream valid.
- m_tready  in  1  sink ready.
- in_cnt  out  C_COUNT_WIDTH  words accepted in the current run.
- out_cnt  out  C_COUNT_WIDTH  words emitted in the current run.

Behaviour:
- Reset (async assert, sync deassert at use site): state=IDLE, len_q=0, in_cnt=0, out_cnt=0, busy=0, done=0. All handshake outputs are 0 because they are gated by state.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> latch len_q=len, clear both counters.
    - len==0: go to DONE.
    - otherwise: go to RUN.
    - start in any other state is ignored.
  - RUN: when an input beat fires and in_cnt+1==len_q, go to DRAIN.
  - DRAIN: when an output beat fires and out_cnt+1==len_q, go to DONE.
  - DONE: done=1 for exactly this one cycle, then go to IDLE. Counters hold their final values until the next start.
- Input join (combinational):
  - in_open = (state==RUN) & (in_cnt<len_q).
  - k_ivalid = in_open & (&s_tvalid).
  - s_tready = {C_NUM_CHANNELS{in_open & k_iready & (&s_tvalid)}}. All channels are accepted together or none is.
  - Input fire = k_ivalid & k_iready; increments in_cnt.
- Output gate (combinational):
  - out_open = (state==RUN | state==DRAIN) & (out_cnt<len_q).
  - m_tvalid = out_open & k_ovalid.
  - k_oready = out_open & m_tready.
  - Output fire = m_tvalid & m_tready; increments out_cnt.
- Input and output may fire in the same cycle, and both counters update. If the output completion coincides with the last input (pipeline depth 0), go directly from RUN to DONE.
- No added latency on handshake paths; counters and state are registered, with a one-cycle update.
- Counters saturate logically at len_q through the gating; no wrap is possible.
- aresetn asserted mid-run: immediate return to reset values. Any beats in flight in the kernel are the kernel's responsibility (its own reset).
- done and busy are never high together.

Optional Feature:
- Macro: FUNC_STREAM_SCHED_PERF_EN.
- When defined:
  - Adds output run_cycles [C_COUNT_WIDTH-1:0], cleared on accepted start and incremented every cycle while busy. It holds its value in DONE/IDLE.
  - Adds output stall_cycles, which counts cycles where k_ivalid & ~k_iready, or m_tvalid & ~m_tready.
- When not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package func_stream_sched_pkg:
  - typedef enum logic [1:0] sched_state_t {IDLE, RUN, DRAIN, DONE}.
  - localparam default count width.
- One sub-module, func_beat_counter: loadable clear, enable increment, and compare-to-limit flag (last and open). It is instantiated twice, for input and output.

Test Plan:
- len=4 with the kernel modelled as a 2-cycle delay and all valids/readies high: in_cnt reaches 4 at 4 cycles, m_tvalid fires 4 times, done pulses once, and busy is high from the cycle after start until done.
- len=0: IDLE->DONE->IDLE; done pulses one cycle after start, no s_tready asserted, busy never high.
- s_tvalid=2'b01 held for 5 cycles, then 2'b11: no s_tready and no in_cnt change during the 5 cycles; both channels become ready together once both are valid.
- len=3, m_tready low for 10 cycles mid-run: k_oready=0 and out_cnt frozen during the stall; after release, out_cnt reaches 3 and done pulses; a 4th kernel k_ovalid is never accepted.
- aresetn pulsed low at in_cnt=2 of len=8: all outputs go to 0 asynchronously; after release the block is in IDLE and start with len=1 completes normally.
- start held high across DONE: only one run per IDLE entry; a new run begins only on the cycle after returning to IDLE, with counters cleared.
